// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the cache-memory bus for two line requesters.
// Serialises READ_LINE / WRITE_LINE transactions and routes beats back to the owner.
module mem_bus_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int BEATS  = 8
) (
    input  logic              clk,
    input  logic              RESET,

    input  logic [1:0]        req_cmd_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              gnt_0,
    output logic              wbeat_0,
    output logic              rsp_valid_0,
    output logic [DATA_W-1:0] rsp_data_0,
    output logic              done_0,

    input  logic [1:0]        req_cmd_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              gnt_1,
    output logic              wbeat_1,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_data_1,
    output logic              done_1,

    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wvalid,
    input  logic              mem_rsp,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WBEAT,
        S_WAIT_RESP,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic              owner, owner_nx;
    logic              is_write, is_write_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic              last_grant, last_grant_nx;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nx;
    logic              rsp_fire;
    logic              elig_0, elig_1, winner;

    // Bit 1 set means READ_LINE or WRITE_LINE; 2'b00 and 2'b01 are both NOP.
    assign elig_0 = req_cmd_0[1];
    assign elig_1 = req_cmd_1[1];

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        is_write_nx   = is_write;
        addr_nx       = addr_q;
        last_grant_nx = last_grant;
        beat_cnt_nx   = beat_cnt;
        rsp_fire      = 1'b0;
        winner        = 1'b0;

        case (state)
            S_IDLE: begin
                if (elig_0 || elig_1) begin
                    winner        = (elig_0 && elig_1) ? ~last_grant : elig_1;
                    owner_nx      = winner;
                    last_grant_nx = winner;
                    is_write_nx   = winner ? req_cmd_1[0] : req_cmd_0[0];
                    addr_nx       = winner ? req_addr_1 : req_addr_0;
                    beat_cnt_nx   = '0;
                    state_nx      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                state_nx = is_write ? S_WBEAT : S_WAIT_RESP;
            end

            S_WBEAT: begin
                beat_cnt_nx = beat_cnt + CNT_W'(1);
                if (beat_cnt == LAST_BEAT) begin
                    state_nx = S_WAIT_RESP;
                end
            end

            S_WAIT_RESP: begin
                if (mem_rsp) begin
                    if (is_write) begin
                        state_nx = S_DONE;
                    end else begin
                        rsp_fire    = 1'b1;
                        beat_cnt_nx = beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state_nx = S_DONE;
                        end
                    end
                end
            end

            S_DONE: begin
                beat_cnt_nx = '0;
                state_nx    = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state       <= S_IDLE;
            owner       <= 1'b0;
            is_write    <= 1'b0;
            addr_q      <= '0;
            last_grant  <= 1'b1;
            beat_cnt    <= '0;
            gnt_0       <= 1'b0;
            gnt_1       <= 1'b0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_data_0  <= '0;
            rsp_data_1  <= '0;
            done_0      <= 1'b0;
            done_1      <= 1'b0;
            mem_cmd     <= '0;
            mem_addr    <= '0;
            mem_wvalid  <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            is_write   <= is_write_nx;
            addr_q     <= addr_nx;
            last_grant <= last_grant_nx;
            beat_cnt   <= beat_cnt_nx;

            gnt_0 <= (state_nx != S_IDLE) && !owner_nx;
            gnt_1 <= (state_nx != S_IDLE) &&  owner_nx;

            mem_cmd    <= (state_nx == S_ISSUE) ? {1'b1, is_write_nx} : 2'b00;
            mem_addr   <= (state_nx == S_ISSUE) ? addr_nx : '0;
            mem_wvalid <= (state_nx == S_WBEAT);

            rsp_valid_0 <= rsp_fire && !owner;
            rsp_valid_1 <= rsp_fire &&  owner;
            if (rsp_fire && !owner) begin
                rsp_data_0 <= mem_rdata;
            end
            if (rsp_fire && owner) begin
                rsp_data_1 <= mem_rdata;
            end

            done_0 <= (state_nx == S_DONE) && !owner_nx;
            done_1 <= (state_nx == S_DONE) &&  owner_nx;
        end
    end

    assign wbeat_0   = (state == S_WBEAT) && !owner;
    assign wbeat_1   = (state == S_WBEAT) &&  owner;
    assign mem_wdata = mem_wvalid ? (owner ? req_wdata_1 : req_wdata_0) : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected bus events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int BEATS  = 8;

    localparam int K_ISSUE = 0;
    localparam int K_WBEAT = 1;
    localparam int K_RSP   = 2;
    localparam int K_DONE  = 3;

    logic              clk;
    logic              RESET;
    logic [1:0]        req_cmd_0, req_cmd_1;
    logic [ADDR_W-1:0] req_addr_0, req_addr_1;
    logic [DATA_W-1:0] req_wdata_0, req_wdata_1;
    logic              gnt_0, gnt_1, wbeat_0, wbeat_1;
    logic              rsp_valid_0, rsp_valid_1, done_0, done_1;
    logic [DATA_W-1:0] rsp_data_0, rsp_data_1;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wvalid;
    logic              mem_rsp;
    logic [DATA_W-1:0] mem_rdata;

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .BEATS (BEATS)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .req_cmd_0  (req_cmd_0),
        .req_addr_0 (req_addr_0),
        .req_wdata_0(req_wdata_0),
        .gnt_0      (gnt_0),
        .wbeat_0    (wbeat_0),
        .rsp_valid_0(rsp_valid_0),
        .rsp_data_0 (rsp_data_0),
        .done_0     (done_0),
        .req_cmd_1  (req_cmd_1),
        .req_addr_1 (req_addr_1),
        .req_wdata_1(req_wdata_1),
        .gnt_1      (gnt_1),
        .wbeat_1    (wbeat_1),
        .rsp_valid_1(rsp_valid_1),
        .rsp_data_1 (rsp_data_1),
        .done_1     (done_1),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wvalid (mem_wvalid),
        .mem_rsp    (mem_rsp),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int port;
        int rel;
        int data;
        int flags;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_ev;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   issue_cyc = 0;
    int   done_count = 0;
    logic [1:0] prev_gnt = 2'b00;
    logic wb0_prev = 1'b0, wb1_prev = 1'b0;
    logic [DATA_W-1:0] wbase0 = '0, wbase1 = '0;
    int   idx0 = 0, idx1 = 0;

    always @(posedge clk) cyc++;

    // Requester write-data model: present the next beat the cycle after wbeat.
    always begin
        @(posedge clk);
        #1;
        if (!gnt_0) idx0 = 0; else if (wb0_prev) idx0++;
        if (!gnt_1) idx1 = 0; else if (wb1_prev) idx1++;
        req_wdata_0 = wbase0 + DATA_W'(idx0);
        req_wdata_1 = wbase1 + DATA_W'(idx1);
    end

    task automatic check_ev(input ev_t act);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: actual kind=%0d port=%0d rel=%0d data=%h flags=%b, required no event",
                     act.kind, act.port, act.rel, act.data, act.flags[3:0]);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != act.kind || e.port != act.port || e.rel != act.rel ||
                e.data != act.data || e.flags != act.flags) begin
                fails++;
                $display("FAIL bus_event: actual kind=%0d port=%0d rel=%0d data=%h flags=%b, required kind=%0d port=%0d rel=%0d data=%h flags=%b",
                         act.kind, act.port, act.rel, act.data, act.flags[3:0],
                         e.kind, e.port, e.rel, e.data, e.flags[3:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (gnt_0 && gnt_1) begin
            tests++;
            fails++;
            $display("FAIL gnt_exclusive: actual gnt_1,gnt_0=11, required at most one high");
        end
        if (mem_cmd != 2'b00) begin
            tests++;
            if (prev_gnt != 2'b00) begin
                fails++;
                $display("FAIL idle_gap: actual gnt before ISSUE=%b, required 00", prev_gnt);
            end
            issue_cyc    = cyc;
            mon_ev.kind  = K_ISSUE;
            mon_ev.port  = gnt_1 ? 1 : 0;
            mon_ev.rel   = 0;
            mon_ev.data  = int'({mem_cmd, mem_addr});
            mon_ev.flags = int'({gnt_1, gnt_0, 2'b00});
            check_ev(mon_ev);
        end
        if (mem_wvalid) begin
            mon_ev.kind  = K_WBEAT;
            mon_ev.port  = wbeat_1 ? 1 : 0;
            mon_ev.rel   = cyc - issue_cyc;
            mon_ev.data  = int'(mem_wdata);
            mon_ev.flags = int'({gnt_1, gnt_0, wbeat_1, wbeat_0});
            check_ev(mon_ev);
        end
        if (rsp_valid_0 || rsp_valid_1) begin
            mon_ev.kind  = K_RSP;
            mon_ev.port  = rsp_valid_1 ? 1 : 0;
            mon_ev.rel   = cyc - issue_cyc;
            mon_ev.data  = int'(rsp_valid_1 ? rsp_data_1 : rsp_data_0);
            mon_ev.flags = int'({gnt_1, gnt_0, rsp_valid_1, rsp_valid_0});
            check_ev(mon_ev);
        end
        if (done_0 || done_1) begin
            done_count++;
            mon_ev.kind  = K_DONE;
            mon_ev.port  = done_1 ? 1 : 0;
            mon_ev.rel   = cyc - issue_cyc;
            mon_ev.data  = 0;
            mon_ev.flags = int'({gnt_1, gnt_0, done_1, done_0});
            check_ev(mon_ev);
        end
        prev_gnt = {gnt_1, gnt_0};
        wb0_prev = wbeat_0;
        wb1_prev = wbeat_1;
    end

    task automatic push(input int kind, input int port, input int rel, input int data, input int flags);
        ev_t e;
        e.kind = kind; e.port = port; e.rel = rel; e.data = data; e.flags = flags;
        exp_q.push_back(e);
    endtask

    // mask bit s = memory pulse in cycle s+1 after ISSUE.
    task automatic expect_txn(input int port, input bit wr, input int addr, input int base, input logic [31:0] mask);
        int fl;
        int cnt;
        bit fin;
        fl  = port ? 'b1010 : 'b0101;
        cnt = 0;
        fin = 0;
        push(K_ISSUE, port, 0, ((wr ? 3 : 2) << ADDR_W) | addr, port ? 'b1000 : 'b0100);
        if (wr) begin
            for (int k = 0; k < BEATS; k++) push(K_WBEAT, port, 1 + k, (base + k) & 'hFFFF, fl);
            for (int s = 0; s < 32; s++) begin
                if (!fin && mask[s] && s >= BEATS) begin
                    push(K_DONE, port, s + 2, 0, fl);
                    fin = 1;
                end
            end
        end else begin
            for (int s = 0; s < 32; s++) begin
                if (mask[s] && cnt < BEATS) begin
                    push(K_RSP, port, s + 2, (base + cnt) & 'hFFFF, fl);
                    cnt++;
                    if (cnt == BEATS) push(K_DONE, port, s + 2, 0, fl);
                end
            end
        end
    endtask

    task automatic set_req(input int port, input logic [1:0] cmd, input logic [ADDR_W-1:0] addr);
        if (port == 0) begin req_cmd_0 = cmd; req_addr_0 = addr; end
        else           begin req_cmd_1 = cmd; req_addr_1 = addr; end
    endtask

    task automatic wait_issue(input int port, output bit got);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            #1;
            if (mem_cmd != 2'b00) got = 1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL issue_timeout: actual no ISSUE in 50 cycles, required ISSUE for requester %0d", port);
        end
    endtask

    task automatic serve(input int port, input int base, input logic [31:0] mask,
                         input bit release_req, input bit perturb);
        int rel, last, d0, cnt;
        bit got, released;
        last = -1;
        for (int s = 0; s < 32; s++) if (mask[s]) last = s;
        wait_issue(port, got);
        if (!got) begin
            set_req(port, 2'b00, '0);
            return;
        end
        d0 = done_count; released = 0; rel = 0; cnt = 0;
        while (!(released && rel > last + 1)) begin
            @(posedge clk);
            #1;
            rel++;
            if (!released && done_count > d0) begin
                released = 1;
                if (release_req) set_req(port, 2'b00, '0);
            end
            if (perturb && rel == 2) set_req(port, 2'b10, 10'h3FF);
            if (rel - 1 < 32 && mask[rel-1]) begin
                mem_rsp   = 1'b1;
                mem_rdata = DATA_W'(base + cnt);
                cnt++;
            end else begin
                mem_rsp = 1'b0;
            end
            if (rel > 60) begin
                tests++;
                fails++;
                $display("FAIL done_timeout: actual no done in 60 cycles, required done for requester %0d", port);
                mem_rsp = 1'b0;
                set_req(port, 2'b00, '0);
                return;
            end
        end
        mem_rsp = 1'b0;
    endtask

    function automatic logic [80:0] outs();
        return {gnt_0, gnt_1, wbeat_0, wbeat_1, rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1,
                done_0, done_1, mem_cmd, mem_addr, mem_wdata, mem_wvalid};
    endfunction

    task automatic check_outs_zero(input string name);
        tests++;
        if (outs() !== '0) begin
            fails++;
            $display("FAIL %s: actual outputs=%h, required all zero", name, outs());
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        RESET = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        bit got;
        int d0;
        RESET = 1'b1;
        req_cmd_0 = 2'b00; req_addr_0 = '0;
        req_cmd_1 = 2'b00; req_addr_1 = '0;
        mem_rsp = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs_zero("reset_outputs");
        @(posedge clk);
        #1;
        RESET = 1'b0;
        @(posedge clk);
        #1;

        // Read on requester 0, beats start 3 cycles after ISSUE.
        expect_txn(0, 0, 'h01A, 'h1000, 32'h0000_03FC);
        set_req(0, 2'b10, 10'h01A);
        serve(0, 'h1000, 32'h0000_03FC, 1, 0);

        // Write on requester 1, ack 2 cycles after the last beat.
        wbase1 = 16'h00A0;
        expect_txn(1, 1, 'h2B4, 'h00A0, 32'h0000_0200);
        set_req(1, 2'b11, 10'h2B4);
        serve(1, 0, 32'h0000_0200, 1, 0);

        // Tie from reset with requests held: 0, 1, 0, 1.
        do_reset(2);
        expect_txn(0, 0, 'h100, 'h3000, 32'h0000_00FF);
        expect_txn(1, 0, 'h200, 'h3100, 32'h0000_00FF);
        expect_txn(0, 0, 'h100, 'h3200, 32'h0000_00FF);
        expect_txn(1, 0, 'h200, 'h3300, 32'h0000_00FF);
        set_req(0, 2'b10, 10'h100);
        set_req(1, 2'b10, 10'h200);
        serve(0, 'h3000, 32'h0000_00FF, 0, 0);
        serve(1, 'h3100, 32'h0000_00FF, 0, 0);
        serve(0, 'h3200, 32'h0000_00FF, 1, 0);
        serve(1, 'h3300, 32'h0000_00FF, 1, 0);

        // Gapped read: pulses 1,0,1,1,0,0,1,1,1,1,0,1 then two extra pulses past the 8th beat.
        expect_txn(0, 0, 'h133, 'h2000, 32'h0000_3BCD);
        set_req(0, 2'b10, 10'h133);
        serve(0, 'h2000, 32'h0000_3BCD, 1, 0);

        // Write with owner request changed mid-burst and a stray pulse during the beats.
        wbase0 = 16'h00B0;
        expect_txn(0, 1, 'h0F0, 'h00B0, 32'h0000_0104);
        set_req(0, 2'b11, 10'h0F0);
        serve(0, 0, 32'h0000_0104, 1, 1);

        // Reset during the 4th read beat: three beats delivered, no done.
        push(K_ISSUE, 0, 0, (2 << ADDR_W) | 'h055, 'b0100);
        for (int k = 0; k < 3; k++) push(K_RSP, 0, 2 + k, 'h4000 + k, 'b0101);
        d0 = done_count;
        set_req(0, 2'b10, 10'h055);
        wait_issue(0, got);
        for (int r = 1; r <= 4; r++) begin
            @(posedge clk);
            #1;
            mem_rsp   = 1'b1;
            mem_rdata = DATA_W'('h4000 + r - 1);
            if (r == 4) RESET = 1'b1;
        end
        @(posedge clk);
        #1;
        RESET = 1'b0;
        mem_rsp = 1'b0;
        set_req(0, 2'b00, '0);
        @(negedge clk);
        check_outs_zero("outputs_after_midread_reset");
        tests++;
        if (done_count != d0) begin
            fails++;
            $display("FAIL no_done_on_reset: actual done pulses=%0d, required 0", done_count - d0);
        end
        @(posedge clk);
        #1;
        expect_txn(1, 0, 'h0C3, 'h5000, 32'h0000_00FF);
        set_req(1, 2'b10, 10'h0C3);
        serve(1, 'h5000, 32'h0000_00FF, 1, 0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_events: actual %0d unmatched, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running at 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
